// File: rtl/mdu_ctrl.sv
// MIPS-style multiply/divide unit controller.
// Multiplies and HI/LO moves complete at the edge that accepts them. Divides use a
// 32-cycle restoring divider, then one sign-fix cycle, then one DONE cycle that
// releases the stalled pipeline.
module mdu_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;        // quotient bit index within RUN
    logic [32:0] rem_q;        // partial remainder
    logic [31:0] quo_q;        // dividend magnitude shifting out, quotient shifting in
    logic [31:0] dvs_q;        // divisor magnitude
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [31:0] hi_q, lo_q;

    logic        accept;
    logic        op_div;
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] a_mag, b_mag;
    logic [33:0] shifted, diff;
    logic [32:0] rem_step;
    logic        quo_bit;
    logic [31:0] quo_final, rem_final;

    // Decode, multiplier and one restoring-division step.
    always_comb begin
        accept     = start && (state_q == IDLE) && (op != OP_NONE) && (op != OP_RSVD);
        op_div     = (op == OP_DIV) || (op == OP_DIVU);
        mul_signed = (op == OP_MULT);
        a_ext      = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext      = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product    = a_ext * b_ext;
        // Magnitudes stay 32-bit unsigned, so |0x80000000| is 0x80000000.
        a_mag      = ((op == OP_DIV) && a[31]) ? (~a + 32'd1) : a;
        b_mag      = ((op == OP_DIV) && b[31]) ? (~b + 32'd1) : b;
        // The remainder is always below the divisor, so the borrow lands in bit 33.
        shifted    = {rem_q, quo_q[31]};
        diff       = shifted - {2'b00, dvs_q};
        quo_bit    = ~diff[33];
        rem_step   = quo_bit ? diff[32:0] : shifted[32:0];
        quo_final  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        rem_final  = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and ready/busy decode.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ready   = 1'b1;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && op_div) begin
                    state_d = RUN;
                    ready   = 1'b0;
                end
            end
            RUN: begin
                ready = 1'b0;
                busy  = 1'b1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                ready   = 1'b0;
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The pipeline must never see a stall while the unit is held in reset.
        if (!resetn) ready = 1'b1;
    end

    // Datapath and architectural HI/LO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= 5'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: {hi_q, lo_q} <= product;
                            OP_MTHI:           hi_q <= a;
                            OP_MTLO:           lo_q <= a;
                            OP_DIV, OP_DIVU: begin
                                cnt_q      <= 5'd0;
                                rem_q      <= 33'd0;
                                quo_q      <= a_mag;
                                dvs_q      <= b_mag;
                                neg_quo_q  <= (op == OP_DIV) && (a[31] ^ b[31]);
                                neg_rem_q  <= (op == OP_DIV) && a[31];
                                div_zero_q <= (b == 32'd0);
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= {quo_q[30:0], quo_bit};
                    cnt_q <= cnt_q + 5'd1;
                end
                FIX: begin
                    // With a zero divisor the remainder already equals |a|, and the
                    // remainder sign fix turns it back into a; only lo is forced.
                    lo_q <= div_zero_q ? 32'hFFFF_FFFF : quo_final;
                    hi_q <= rem_final;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have: start  in  1  EX-stage MDU instruction valid; held high by the pipeline while stalled.
REQ-003 SHALL have: op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-004 SHALL have: a, b  in  32 each  rs/rt operands, sampled only on accept.
REQ-005 SHALL have: ready  out  1  MDU ready, feeds hazard-unit stall input (low stalls F/D/E).
REQ-006 SHALL have: busy  out  1  divide in progress; hi, lo  out  32 each  architectural HI/LO register values.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-008 Accept = start & state==IDLE & op!=none/reserved.
REQ-009 MULT/MULTU accepted: {hi,lo} SHALL take the 64-bit signed/unsigned product at the next edge; ready stays 1; FSM stays IDLE.
REQ-010 MTHI/MTLO accepted: hi (resp. lo) SHALL take a at the next edge; other register unchanged; ready stays 1.
REQ-011 DIV/DIVU accepted: ready SHALL go 0 combinationally in the accept cycle; FSM -> RUN; latch |a|,|b| (signed) or a,b (unsigned) plus result signs; iteration counter cleared to 0.
REQ-012 RUN: one restoring radix-2 quotient bit per cycle, MSB first, 32 cycles (counter 0..31); after counter 31 -> FIX.
REQ-013 FIX: apply sign correction (quotient negated if sign(a)^sign(b), remainder negated if sign(a), signed ops only); write lo=quotient, hi=remainder at this edge; -> DONE.
REQ-014 DONE: ready SHALL be 1 for exactly this cycle; start SHALL be ignored in DONE (the stalled instruction is retiring); -> IDLE unconditionally.
REQ-015 ready = 0 in accept-of-divide cycle, RUN and FIX; 1 in IDLE (otherwise) and DONE; total stall per divide = 34 cycles.
REQ-016 busy SHALL be 1 in RUN and FIX only.
REQ-017 Divide by zero (b==0, signed or unsigned): lo SHALL become 0xFFFFFFFF, hi SHALL become a; same 34-cycle timing.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no trap.
REQ-019 hi/lo SHALL be unchanged during RUN and until the FIX edge; reads in stalled cycles see the old values.
REQ-020 Changes on a, b, op during RUN/FIX SHALL have no effect.
REQ-021 All widths: internal partial remainder 33 bits; magnitudes 32 bits unsigned; no truncation of |0x80000000|.

Reset
REQ-022 resetn low SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0; ready=1 while in reset.
REQ-023 Reset asserted mid-divide SHALL abort it; hi/lo = 0; no partial result written.
REQ-024 After resetn deasserts, the first rising edge with start high SHALL be able to accept an operation.

Verification
REQ-025 MULT a=0xFFFFFFFE (-2), b=3 -> next edge hi=0xFFFFFFFF, lo=0xFFFFFFFA; ready never low.
REQ-026 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-027 DIV a=-7 (0xFFFFFFF9), b=2 held with start -> ready low 34 cycles, busy high 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF at FIX edge; ready high one cycle in DONE; no second accept.
REQ-028 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 after 34-cycle stall; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 DIVU started, resetn pulsed low at RUN counter 10 -> ready=1, busy=0, hi=lo=0 immediately; subsequent MTHI a=0x1234 -> hi=0x1234 next edge.
REQ-030 MTLO a=0xA5A5A5A5 then MFLO-equivalent read of lo in the following cycle -> lo=0xA5A5A5A5, hi unchanged.
